// File: rtl/crp16_alu_pkg.sv
// Shared definitions for the CRP16 multi-cycle multiply/divide sequencer.
//   MD_MUL / MD_DIV : op encodings carried on the 'op' port
//   MD_ITER         : iterations per operation (operand width)
//   md_state_e      : sequencer state encoding
package crp16_alu_pkg;

  localparam logic MD_MUL  = 1'b0;
  localparam logic MD_DIV  = 1'b1;
  localparam int   MD_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/crp16_alu_adder.sv
// 16-bit adder/subtractor shared by the multiply and divide iterations.
//   x, y  : operands
//   sub   : 0 = x + y, 1 = x - y (two's complement, x + ~y + 1)
//   r     : 16-bit result
//   c_out : carry out; when subtracting, 1 means no borrow (x >= y)
//   v     : signed overflow
module crp16_alu_adder (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        sub,
  output logic [15:0] r,
  output logic        c_out,
  output logic        v
);

  logic [15:0] y_eff;
  logic [16:0] sum;

  always_comb begin
    y_eff = y ^ {16{sub}};
    sum   = {1'b0, x} + {1'b0, y_eff} + {16'd0, sub};
  end

  assign r     = sum[15:0];
  assign c_out = sum[16];
  assign v     = (x[15] == y_eff[15]) && (r[15] != x[15]);

endmodule

// File: rtl/crp16_alu_muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply / 16/16 divide sequencer.
// One shared adder is used per cycle: shift-add for MUL, restoring
// subtract-compare for DIV.
//   clk, rst_n      : clock, async active-low reset
//   start, op, a, b : request; op/a/b latched when start is accepted
//   busy            : operation in progress (start ignored)
//   done            : one-cycle pulse, results valid
//   res_lo / res_hi : MUL product[15:0]/[31:16]; DIV quotient/remainder
//   dbz             : last DIV had a zero divisor
//
// state   | meaning
// IDLE    | waiting for start (also the one-cycle hold before a div-by-zero DONE)
// RUN     | iterating, one adder pass per cycle
// DONE    | results valid, done pulse; start may be accepted here
module crp16_alu_muldiv_seq
  import crp16_alu_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_lo,
  output logic [15:0] res_hi,
  output logic        dbz
);

  localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

  md_state_e   state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        op_q, op_d;
  logic [15:0] b_q, b_d;
  // hi holds acc_hi (MUL) or rem[15:0] (DIV); lo holds acc_lo or q.
  // rem[16] is always 0 after an iteration, so it needs no storage.
  logic [15:0] hi_q, hi_d;
  logic [15:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  // Divide-by-zero results are loaded at acceptance; done follows one cycle later.
  logic        pend_q, pend_d;

  logic [16:0] s_div;
  logic [15:0] add_x;
  logic [15:0] add_r;
  logic        add_c;
  logic        adder_v_unused;
  logic        take;

  always_comb begin
    s_div = {hi_q, lo_q[15]};
    add_x = (op_q == MD_MUL) ? hi_q : s_div[15:0];
    take  = s_div[16] | add_c;
  end

  crp16_alu_adder u_adder (
    .x     (add_x),
    .y     (b_q),
    .sub   (op_q),
    .r     (add_r),
    .c_out (add_c),
    .v     (adder_v_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    pend_d  = 1'b0;

    case (state_q)
      ST_RUN: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (op_q == MD_MUL) begin
          if (lo_q[0]) {hi_d, lo_d} = {add_c, add_r, lo_q[15:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[15:1]};
        end else begin
          hi_d = take ? add_r : s_div[15:0];
          lo_d = {lo_q[14:0], take};
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        if (start) begin
          op_d  = op;
          b_d   = b;
          cnt_d = 5'd0;
          dbz_d = 1'b0;
          if (op == MD_DIV && b == 16'd0) begin
            hi_d   = a;
            lo_d   = 16'hFFFF;
            dbz_d  = 1'b1;
            pend_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            hi_d    = 16'd0;
            lo_d    = a;
          end
        end else if (pend_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= MD_MUL;
      b_q     <= 16'd0;
      hi_q    <= 16'd0;
      lo_q    <= 16'd0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign res_lo = lo_q;
  assign res_hi = hi_q;
  assign dbz    = dbz_q;

endmodule
